// File: rtl/wb_decoder_pkg.sv
// Shared definitions for the Wishbone address decoder: slave count,
// select-field position, error read data and the FSM state encoding.
package wb_decoder_pkg;

    localparam int NUM_SLAVES = 4;
    localparam int SEL_W      = 2;

    // Address bits that pick the slave; bits above SEL_HI must be zero
    localparam int SEL_HI = 19;
    localparam int SEL_LO = 16;

    // Read data returned with an error acknowledge
    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Fixed encodings kept for older blocks that compare raw state bits
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_BUSY = S_BUSY,
        ST_ERR  = S_ERR,
        ST_RESP = S_RESP
    } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Counts cycles a slave has spent in its bus cycle and flags when it has
// been silent for TIMEOUT_CYCLES cycles. Only built when the decoder is
// compiled with WB_DECODER_TIMEOUT_EN.
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign expired = run && (count == LAST);

    // Count while running, restart from zero whenever cleared, hold at the end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_addr_decoder.sv
// Wishbone 1-to-4 address decoder with registered request/response path.
// Slave select is taken from address bits [19:16]; anything outside the
// four slave windows is answered with an error ack and 0xDEAD_BEEF.
// Optional slave timeout: define WB_DECODER_TIMEOUT_EN.
module wb_addr_decoder
    import wb_decoder_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         wb_clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_W-1:0]            m_addr_i,
    input  logic [DATA_W-1:0]            m_wdata_i,
    input  logic                         m_wr_en_i,
    input  logic [DATA_W/8-1:0]          m_byte_en_i,
    input  logic                         m_stb_i,
    input  logic                         m_cyc_i,
    output logic [DATA_W-1:0]            m_rdata_o,
    output logic                         m_ack_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W-1:0]            s_wdata_o,
    output logic                         s_wr_en_o,
    output logic [DATA_W/8-1:0]          s_byte_en_o,
    output logic [NUM_SLAVES-1:0]        s_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_stb_o,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i,
    output logic                         err_flag_o,
    input  logic                         err_clr_i
);

    state_e                 state;
    logic [SEL_W-1:0]       sel_q;
    logic [SEL_HI-SEL_LO:0] sel_field;
    logic                   addr_mapped;
    logic                   ack_sel;
    logic [DATA_W-1:0]      rdata_sel;
    logic                   tmo_expired;

    assign sel_field   = m_addr_i[SEL_HI:SEL_LO];
    assign addr_mapped = ((m_addr_i >> (SEL_HI + 1)) == '0) &&
                         (sel_field < (SEL_HI - SEL_LO + 1)'(NUM_SLAVES));

    // Only the selected slave's ack and data are ever looked at
    assign ack_sel   = s_ack_i[sel_q];
    assign rdata_sel = s_rdata_i[sel_q*DATA_W +: DATA_W];

`ifdef WB_DECODER_TIMEOUT_EN
    wb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (wb_clk_i),
        .rst    (rst_i),
        .clear  (state != ST_BUSY),
        .run    (state == ST_BUSY),
        .expired(tmo_expired)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    // Transaction FSM: accept, run one slave cycle, respond, wait for release
    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            s_cyc_o     <= '0;
            s_stb_o     <= '0;
            m_ack_o     <= 1'b0;
            m_rdata_o   <= '0;
            s_addr_o    <= '0;
            s_wdata_o   <= '0;
            s_wr_en_o   <= 1'b0;
            s_byte_en_o <= '0;
        end else begin
            m_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_addr_o    <= m_addr_i;
                        s_wdata_o   <= m_wdata_i;
                        s_wr_en_o   <= m_wr_en_i;
                        s_byte_en_o <= m_byte_en_i;
                        sel_q       <= sel_field[SEL_W-1:0];
                        if (addr_mapped) begin
                            s_cyc_o <= NUM_SLAVES'(1) << sel_field[SEL_W-1:0];
                            s_stb_o <= NUM_SLAVES'(1) << sel_field[SEL_W-1:0];
                            state   <= ST_BUSY;
                        end else begin
                            state   <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ack_sel) begin
                        m_rdata_o <= rdata_sel;
                        m_ack_o   <= 1'b1;
                        s_cyc_o   <= '0;
                        s_stb_o   <= '0;
                        state     <= ST_RESP;
                    end else if (tmo_expired) begin
                        s_cyc_o   <= '0;
                        s_stb_o   <= '0;
                        state     <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    m_ack_o   <= 1'b1;
                    m_rdata_o <= DATA_W'(ERR_RDATA);
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (!m_stb_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear
    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            err_flag_o <= 1'b0;
        end else if (state == ST_ERR) begin
            err_flag_o <= 1'b1;
        end else if (err_clr_i) begin
            err_flag_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Directed self-checking bench for wb_addr_decoder. The timeout scenario is
// only compiled when WB_DECODER_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 8).
module tb_wb_addr_decoder;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                wb_clk_i = 1'b0;
    logic                rst_i;
    logic [ADDR_W-1:0]   m_addr_i;
    logic [DATA_W-1:0]   m_wdata_i;
    logic                m_wr_en_i;
    logic [3:0]          m_byte_en_i;
    logic                m_stb_i;
    logic                m_cyc_i;
    logic [DATA_W-1:0]   m_rdata_o;
    logic                m_ack_o;
    logic [ADDR_W-1:0]   s_addr_o;
    logic [DATA_W-1:0]   s_wdata_o;
    logic                s_wr_en_o;
    logic [3:0]          s_byte_en_o;
    logic [3:0]          s_cyc_o;
    logic [3:0]          s_stb_o;
    logic [3:0]          s_ack_i;
    logic [4*DATA_W-1:0] s_rdata_i;
    logic                err_flag_o;
    logic                err_clr_i;

    int checks = 0;
    int errors = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_addr_decoder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .rst_i      (rst_i),
        .m_addr_i   (m_addr_i),
        .m_wdata_i  (m_wdata_i),
        .m_wr_en_i  (m_wr_en_i),
        .m_byte_en_i(m_byte_en_i),
        .m_stb_i    (m_stb_i),
        .m_cyc_i    (m_cyc_i),
        .m_rdata_o  (m_rdata_o),
        .m_ack_o    (m_ack_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_wr_en_o  (s_wr_en_o),
        .s_byte_en_o(s_byte_en_o),
        .s_cyc_o    (s_cyc_o),
        .s_stb_o    (s_stb_o),
        .s_ack_i    (s_ack_i),
        .s_rdata_i  (s_rdata_i),
        .err_flag_o (err_flag_o),
        .err_clr_i  (err_clr_i)
    );

    // Advance one clock and settle just after the active edge
    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic we, input logic [3:0] be);
        m_addr_i    = addr;
        m_wdata_i   = wdata;
        m_wr_en_i   = we;
        m_byte_en_i = be;
        m_cyc_i     = 1'b1;
        m_stb_i     = 1'b1;
    endtask

    task automatic end_req();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        end_req();
        m_addr_i = '0; m_wdata_i = '0; m_wr_en_i = 1'b0; m_byte_en_i = '0;
        s_ack_i = '0; s_rdata_i = '0; err_clr_i = 1'b0;
        step();
        step();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got=%b exp=0", m_ack_o); end
        checks++; if (s_cyc_o !== 4'b0000 || s_stb_o !== 4'b0000) begin errors++; $display("[TB] FAIL reset_cyc_stb got=%b/%b exp=0000", s_cyc_o, s_stb_o); end
        checks++; if (err_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b exp=0", err_flag_o); end
        checks++; if (m_rdata_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata got=%h exp=0", m_rdata_o); end
        checks++; if (s_addr_o !== 32'h0 || s_wdata_o !== 32'h0 || s_wr_en_o !== 1'b0 || s_byte_en_o !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_bcast got=%h/%h/%b/%b exp=0", s_addr_o, s_wdata_o, s_wr_en_o, s_byte_en_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_read();
        s_rdata_i[1*DATA_W +: DATA_W] = 32'h1111_1111;
        s_rdata_i[2*DATA_W +: DATA_W] = 32'h1234_5678;
        start_req(32'h0002_0010, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b0100 || s_stb_o !== 4'b0100) begin errors++; $display("[TB] FAIL read_sel got=%b/%b exp=0100", s_cyc_o, s_stb_o); end
        checks++; if (s_addr_o !== 32'h0002_0010) begin errors++; $display("[TB] FAIL read_addr got=%h exp=00020010", s_addr_o); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 4'b0100) begin errors++; $display("[TB] FAIL read_wait%0d ack=%b cyc=%b exp 0/0100", i, m_ack_o, s_cyc_o); end
            if (i < 2) step();
        end
        s_ack_i = 4'b0100;
        step();
        s_ack_i = 4'b0000;
        checks++; if (m_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL read_ack got=%b exp=1", m_ack_o); end
        checks++; if (m_rdata_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_rdata got=%h exp=12345678", m_rdata_o); end
        checks++; if (s_cyc_o !== 4'b0000) begin errors++; $display("[TB] FAIL read_cyc_drop got=%b exp=0000", s_cyc_o); end
        end_req();
        step();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL read_ack_single got=%b exp=0", m_ack_o); end
        checks++; if (m_rdata_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL read_rdata_hold got=%h exp=12345678", m_rdata_o); end
        checks++; if (err_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL read_err got=%b exp=0", err_flag_o); end
        step();
    endtask

    task automatic test_write();
        s_rdata_i[0*DATA_W +: DATA_W] = 32'h0000_00AA;
        start_req(32'h0000_0004, 32'hCAFE_0001, 1'b1, 4'b0011);
        step();
        checks++; if (s_cyc_o !== 4'b0001 || s_stb_o !== 4'b0001) begin errors++; $display("[TB] FAIL write_sel got=%b/%b exp=0001", s_cyc_o, s_stb_o); end
        checks++; if (s_addr_o !== 32'h0000_0004 || s_wdata_o !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL write_bcast got=%h/%h exp=00000004/cafe0001", s_addr_o, s_wdata_o); end
        checks++; if (s_wr_en_o !== 1'b1 || s_byte_en_o !== 4'b0011) begin errors++; $display("[TB] FAIL write_ctrl got=%b/%b exp=1/0011", s_wr_en_o, s_byte_en_o); end
        s_ack_i = 4'b0001;
        step();
        s_ack_i = 4'b0000;
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL write_ack got=%b/%h exp=1/000000aa", m_ack_o, m_rdata_o); end
        end_req();
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL write_single%0d got=%b exp=0", i, m_ack_o); end
        end
    endtask

    task automatic test_spurious_ack();
        s_rdata_i[1*DATA_W +: DATA_W] = 32'h0101_0101;
        s_rdata_i[3*DATA_W +: DATA_W] = 32'h0303_0303;
        start_req(32'h0001_0020, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b0010) begin errors++; $display("[TB] FAIL spur_sel got=%b exp=0010", s_cyc_o); end
        s_ack_i = 4'b1000;
        step();
        step();
        checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 4'b0010) begin errors++; $display("[TB] FAIL spur_ignored ack=%b cyc=%b exp 0/0010", m_ack_o, s_cyc_o); end
        s_ack_i = 4'b0010;
        step();
        s_ack_i = 4'b0000;
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'h0101_0101) begin errors++; $display("[TB] FAIL spur_ack got=%b/%h exp=1/01010101", m_ack_o, m_rdata_o); end
        end_req();
        step();
        step();
    endtask

    task automatic test_back_to_back();
        s_rdata_i[0*DATA_W +: DATA_W] = 32'h0B0B_0B0B;
        start_req(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        step();
        s_ack_i = 4'b0001;
        step();
        s_ack_i = 4'b0000;
        checks++; if (m_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ack got=%b exp=1", m_ack_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 4'b0000) begin errors++; $display("[TB] FAIL b2b_hold%0d ack=%b cyc=%b exp 0/0000", i, m_ack_o, s_cyc_o); end
        end
        end_req();
        step();
        checks++; if (m_ack_o !== 1'b0 || s_cyc_o !== 4'b0000 || m_rdata_o !== 32'h0B0B_0B0B) begin
            errors++; $display("[TB] FAIL b2b_release ack=%b cyc=%b rdata=%h exp 0/0000/0b0b0b0b", m_ack_o, s_cyc_o, m_rdata_o);
        end
        step();
    endtask

    task automatic test_unmapped();
        start_req(32'h0005_0000, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b0000 || m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL unmap_err_state cyc=%b ack=%b exp 0000/0", s_cyc_o, m_ack_o); end
        step();
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL unmap_ack got=%b/%h exp=1/deadbeef", m_ack_o, m_rdata_o); end
        checks++; if (err_flag_o !== 1'b1 || s_cyc_o !== 4'b0000) begin errors++; $display("[TB] FAIL unmap_flag err=%b cyc=%b exp 1/0000", err_flag_o, s_cyc_o); end
        end_req();
        step();
        checks++; if (m_ack_o !== 1'b0 || err_flag_o !== 1'b1) begin errors++; $display("[TB] FAIL unmap_sticky ack=%b err=%b exp 0/1", m_ack_o, err_flag_o); end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        checks++; if (err_flag_o !== 1'b0) begin errors++; $display("[TB] FAIL unmap_clear got=%b exp=0", err_flag_o); end
        // High address bit set with a valid select field is still unmapped;
        // clear is held during the error cycle so set must win
        start_req(32'h0010_0000, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b0000) begin errors++; $display("[TB] FAIL unmap_hi_sel got=%b exp=0000", s_cyc_o); end
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'hDEAD_BEEF || err_flag_o !== 1'b1) begin
            errors++; $display("[TB] FAIL unmap_set_wins ack=%b rdata=%h err=%b exp 1/deadbeef/1", m_ack_o, m_rdata_o, err_flag_o);
        end
        end_req();
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        start_req(32'h0001_0000, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b0010) begin errors++; $display("[TB] FAIL rstmid_sel got=%b exp=0010", s_cyc_o); end
        step();
        rst_i = 1'b1;
        end_req();
        step();
        checks++; if (s_cyc_o !== 4'b0000 || s_stb_o !== 4'b0000 || m_ack_o !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_abort cyc=%b stb=%b ack=%b exp 0000/0000/0", s_cyc_o, s_stb_o, m_ack_o);
        end
        rst_i = 1'b0;
        step();
        checks++; if (m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_noack got=%b exp=0", m_ack_o); end
        s_rdata_i[3*DATA_W +: DATA_W] = 32'h3333_0003;
        start_req(32'h0003_0008, 32'h0, 1'b0, 4'hF);
        step();
        checks++; if (s_cyc_o !== 4'b1000) begin errors++; $display("[TB] FAIL rstmid_s3_sel got=%b exp=1000", s_cyc_o); end
        s_ack_i = 4'b1000;
        step();
        s_ack_i = 4'b0000;
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'h3333_0003) begin errors++; $display("[TB] FAIL rstmid_s3_ack got=%b/%h exp=1/33330003", m_ack_o, m_rdata_o); end
        end_req();
        step();
        step();
    endtask

`ifdef WB_DECODER_TIMEOUT_EN
    task automatic test_timeout();
        start_req(32'h0001_0000, 32'h0, 1'b0, 4'hF);
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++; if (s_cyc_o !== 4'b0010 || m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL tmo_busy%0d cyc=%b ack=%b exp 0010/0", i, s_cyc_o, m_ack_o); end
            s_ack_i = (i == 4) ? 4'b1000 : 4'b0000;
        end
        step();
        checks++; if (s_cyc_o !== 4'b0000 || m_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL tmo_drop cyc=%b ack=%b exp 0000/0", s_cyc_o, m_ack_o); end
        step();
        checks++; if (m_ack_o !== 1'b1 || m_rdata_o !== 32'hDEAD_BEEF || err_flag_o !== 1'b1) begin
            errors++; $display("[TB] FAIL tmo_err ack=%b rdata=%h err=%b exp 1/deadbeef/1", m_ack_o, m_rdata_o, err_flag_o);
        end
        end_req();
        step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
    endtask
`endif

    // Run each scenario in turn and print the summary
    initial begin
        test_reset();
        test_read();
        test_write();
        test_spurious_ack();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
`ifdef WB_DECODER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
